// File: rtl/mat_job_sched.sv
// ============================================================================
// mat_job_sched -- arbitrates two requesters onto one multiply datapath and
// routes results back to the job owner. Revision: 1.0
// ============================================================================
`default_nettype none

module mat_job_sched #(
   parameter int DATA_W  = 8,
   parameter int JOB_LEN = 8
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_clk_e,
   input  logic [DATA_W-1:0] s0_data,
   input  logic              s0_valid,
   output logic              s0_ready,
   input  logic [DATA_W-1:0] s1_data,
   input  logic              s1_valid,
   output logic              s1_ready,
   output logic [DATA_W-1:0] o_mp_data,
   output logic              o_mp_valid,
   input  logic              i_mp_ready,
   input  logic [DATA_W-1:0] i_res_data,
   input  logic              i_res_valid,
   input  logic              i_res_last,
   output logic              o_res_ready,
   output logic [DATA_W-1:0] m0_data,
   output logic              m0_valid,
   output logic              m0_last,
   input  logic              m0_ready,
   output logic [DATA_W-1:0] m1_data,
   output logic              m1_valid,
   output logic              m1_last,
   input  logic              m1_ready,
   output logic [1:0]        o_grant,
   output logic              o_busy
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FEED  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam logic [7:0] C_LAST_BEAT = 8'(JOB_LEN - 1);

   state_t      r_state,    w_state_nxt;
   logic [7:0]  r_beat_cnt, w_beat_cnt_nxt;
   logic [1:0]  r_grant,    w_grant_nxt;
   logic        r_last_srv, w_last_srv_nxt;   // index of the last requester served

   logic              w_sel;
   logic              w_sel_valid;
   logic [DATA_W-1:0] w_sel_data;
   logic              w_sel_m_ready;
   logic              w_feed;
   logic              w_route;
   logic              w_mp_hs;
   logic              w_res_hs;

   assign w_sel         = r_grant[1];
   assign w_sel_valid   = w_sel ? s1_valid : s0_valid;
   assign w_sel_data    = w_sel ? s1_data  : s0_data;
   assign w_sel_m_ready = w_sel ? m1_ready : m0_ready;
   assign w_feed        = (r_state == ST_FEED);
   // Results are accepted while feeding too, to cover pipelined datapaths.
   assign w_route       = (r_state != ST_IDLE);

   assign o_mp_data   = w_sel_data;
   assign o_mp_valid  = w_feed & w_sel_valid;
   assign s0_ready    = w_feed & r_grant[0] & i_mp_ready;
   assign s1_ready    = w_feed & r_grant[1] & i_mp_ready;
   assign o_res_ready = w_route & w_sel_m_ready;

   assign m0_data  = i_res_data;
   assign m1_data  = i_res_data;
   assign m0_valid = w_route & r_grant[0] & i_res_valid;
   assign m1_valid = w_route & r_grant[1] & i_res_valid;
   assign m0_last  = w_route & r_grant[0] & i_res_last;
   assign m1_last  = w_route & r_grant[1] & i_res_last;

   assign o_grant = r_grant;
   assign o_busy  = (r_state != ST_IDLE);

   assign w_mp_hs  = o_mp_valid & i_mp_ready & i_clk_e;
   assign w_res_hs = i_res_valid & o_res_ready & i_clk_e;

   always_comb begin
      w_state_nxt    = r_state;
      w_beat_cnt_nxt = r_beat_cnt;
      w_grant_nxt    = r_grant;
      w_last_srv_nxt = r_last_srv;
      case (r_state)
         ST_IDLE: begin
            if (i_clk_e && (s0_valid || s1_valid)) begin
               if (s0_valid && s1_valid)
                  w_grant_nxt = r_last_srv ? 2'b01 : 2'b10;
               else
                  w_grant_nxt = s0_valid ? 2'b01 : 2'b10;
               w_beat_cnt_nxt = 8'd0;
               w_state_nxt    = ST_FEED;
            end
         end
         ST_FEED: begin
            if (w_mp_hs) begin
               if (r_beat_cnt == C_LAST_BEAT) begin
                  w_beat_cnt_nxt = 8'd0;
                  w_state_nxt    = ST_DRAIN;
               end else begin
                  w_beat_cnt_nxt = r_beat_cnt + 8'd1;
               end
            end
         end
         ST_DRAIN: begin
            if (w_res_hs && i_res_last) begin
               w_last_srv_nxt = w_sel;
               w_grant_nxt    = 2'b00;
               w_state_nxt    = ST_IDLE;
            end
         end
         default: begin
            w_grant_nxt    = 2'b00;
            w_beat_cnt_nxt = 8'd0;
            w_state_nxt    = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= ST_IDLE;
         r_beat_cnt <= 8'd0;
         r_grant    <= 2'b00;
         r_last_srv <= 1'b1;
      end else begin
         r_state    <= w_state_nxt;
         r_beat_cnt <= w_beat_cnt_nxt;
         r_grant    <= w_grant_nxt;
         r_last_srv <= w_last_srv_nxt;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mat_job_sched.sv
// ============================================================================
// tb_mat_job_sched -- job-level reference model plus directed and random
// stimulus for mat_job_sched. Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mat_job_sched;

   localparam int JL = 8;

   logic       clk = 1'b0;
   logic       rst_n, clk_e;
   logic [7:0] s0_data, s1_data, res_data;
   logic       s0_valid, s1_valid, mp_ready, res_valid, res_last, m0_ready, m1_ready;

   logic [7:0] mp_data, m0_data, m1_data;
   logic       s0_ready, s1_ready, mp_valid, res_ready;
   logic       m0_valid, m0_last, m1_valid, m1_last, busy;
   logic [1:0] grant;

   logic [7:0] b_mp_data, b_m0_data, b_m1_data;
   logic       b_s0_ready, b_s1_ready, b_mp_valid, b_res_ready;
   logic       b_m0_valid, b_m0_last, b_m1_valid, b_m1_last, b_busy;
   logic [1:0] b_grant;

   always #5 clk = ~clk;

   mat_job_sched #(.DATA_W(8), .JOB_LEN(JL)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_clk_e(clk_e),
      .s0_data(s0_data), .s0_valid(s0_valid), .s0_ready(s0_ready),
      .s1_data(s1_data), .s1_valid(s1_valid), .s1_ready(s1_ready),
      .o_mp_data(mp_data), .o_mp_valid(mp_valid), .i_mp_ready(mp_ready),
      .i_res_data(res_data), .i_res_valid(res_valid), .i_res_last(res_last),
      .o_res_ready(res_ready),
      .m0_data(m0_data), .m0_valid(m0_valid), .m0_last(m0_last), .m0_ready(m0_ready),
      .m1_data(m1_data), .m1_valid(m1_valid), .m1_last(m1_last), .m1_ready(m1_ready),
      .o_grant(grant), .o_busy(busy)
   );

   mat_job_sched #(.DATA_W(8), .JOB_LEN(1)) dut_len1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_clk_e(clk_e),
      .s0_data(s0_data), .s0_valid(s0_valid), .s0_ready(b_s0_ready),
      .s1_data(s1_data), .s1_valid(s1_valid), .s1_ready(b_s1_ready),
      .o_mp_data(b_mp_data), .o_mp_valid(b_mp_valid), .i_mp_ready(mp_ready),
      .i_res_data(res_data), .i_res_valid(res_valid), .i_res_last(res_last),
      .o_res_ready(b_res_ready),
      .m0_data(b_m0_data), .m0_valid(b_m0_valid), .m0_last(b_m0_last), .m0_ready(m0_ready),
      .m1_data(b_m1_data), .m1_valid(b_m1_valid), .m1_last(b_m1_last), .m1_ready(m1_ready),
      .o_grant(b_grant), .o_busy(b_busy)
   );

   // Job-level model: who owns the datapath, how many beats fed, draining or not.
   int   owner, fed, last_srv;
   bit   draining;
   int   n_checks = 0, n_fail = 0;
   int   mp_hs_count, b_hs_count, m0_beats, m0_last_beat;
   logic [7:0] mp_log[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      owner = -1; fed = 0; draining = 0; last_srv = 1;
   endtask

   // Called just after a falling edge with inputs already applied; checks,
   // advances the model over the coming rising edge, returns at the next falling edge.
   task automatic cycle();
      logic [1:0] sv, mr;
      logic [7:0] sd [2];
      int   oi;
      bit   feeding, exp_mpv, was_drain, rhs;
      #1;
      sv = {s1_valid, s0_valid};
      mr = {m1_ready, m0_ready};
      sd[0] = s0_data; sd[1] = s1_data;
      oi = (owner < 0) ? 0 : owner;
      feeding = (owner >= 0) && !draining;
      exp_mpv = feeding && sv[oi];
      chk("busy", busy, owner >= 0);
      chk("grant", grant, owner < 0 ? 0 : (owner == 0 ? 1 : 2));
      chk("mp_valid", mp_valid, exp_mpv);
      if (exp_mpv) chk("mp_data", mp_data, sd[oi]);
      chk("s0_ready", s0_ready, feeding && owner == 0 && mp_ready);
      chk("s1_ready", s1_ready, feeding && owner == 1 && mp_ready);
      chk("res_ready", res_ready, owner >= 0 && mr[oi]);
      chk("m0_valid", m0_valid, owner == 0 && res_valid);
      chk("m1_valid", m1_valid, owner == 1 && res_valid);
      if (owner == 0 && res_valid) begin
         chk("m0_data", m0_data, res_data);
         chk("m0_last", m0_last, res_last);
      end
      if (owner == 1 && res_valid) begin
         chk("m1_data", m1_data, res_data);
         chk("m1_last", m1_last, res_last);
      end
      if (clk_e && mp_valid && mp_ready) begin
         mp_hs_count++;
         mp_log.push_back(mp_data);
      end
      if (clk_e && b_mp_valid && mp_ready) b_hs_count++;
      if (clk_e && m0_valid && m0_ready) begin
         m0_beats++;
         if (m0_last) m0_last_beat = m0_beats;
      end
      if (clk_e) begin
         if (owner < 0) begin
            if (sv == 2'b11)  owner = 1 - last_srv;
            else if (sv[0])   owner = 0;
            else if (sv[1])   owner = 1;
            fed = 0; draining = 0;
         end else begin
            was_drain = draining;
            rhs = res_valid && mr[oi];
            if (feeding && sv[oi] && mp_ready) begin
               fed++;
               if (fed == JL) begin draining = 1; fed = 0; end
            end
            if (was_drain && rhs && res_last) begin
               last_srv = owner; owner = -1; draining = 0;
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic check_reset_outputs();
      chk("rst_s0_ready", s0_ready, 0);   chk("rst_s1_ready", s1_ready, 0);
      chk("rst_mp_valid", mp_valid, 0);   chk("rst_res_ready", res_ready, 0);
      chk("rst_m0_valid", m0_valid, 0);   chk("rst_m1_valid", m1_valid, 0);
      chk("rst_grant", grant, 0);         chk("rst_busy", busy, 0);
      chk("rst_b_mp_valid", b_mp_valid, 0); chk("rst_b_res_ready", b_res_ready, 0);
      chk("rst_b_s0_ready", b_s0_ready, 0); chk("rst_b_s1_ready", b_s1_ready, 0);
      chk("rst_b_grant", b_grant, 0);     chk("rst_b_busy", b_busy, 0);
   endtask

   // Asserted between clock edges so that the clear is seen to be asynchronous.
   task automatic apply_reset();
      rst_n = 1'b0;
      #1;
      check_reset_outputs();
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic run_job(input bit v0, input bit v1, input int nres, output logic [1:0] g);
      s0_valid = v0; s1_valid = v1; clk_e = 1; mp_ready = 1;
      m0_ready = 1; m1_ready = 1; res_valid = 0; res_last = 0; g = 2'b00;
      for (int i = 0; i < 60 && !draining; i++) begin
         s0_data = 8'($urandom); s1_data = 8'($urandom);
         cycle();
         if (busy && g == 2'b00) g = grant;
      end
      chk("feed_reaches_drain", draining, 1);
      s0_valid = 0; s1_valid = 0;
      for (int r = 0; r < nres; r++) begin
         res_valid = 1; res_data = 8'($urandom); res_last = (r == nres - 1);
         cycle();
      end
      res_valid = 0; res_last = 0;
      chk("job_done", owner < 0, 1);
   endtask

   initial begin
      logic [1:0] g;
      rst_n = 0; clk_e = 0; s0_valid = 0; s1_valid = 0; s0_data = 0; s1_data = 0;
      mp_ready = 0; res_valid = 0; res_last = 0; res_data = 0; m0_ready = 0; m1_ready = 0;
      mp_hs_count = 0; b_hs_count = 0; m0_beats = 0; m0_last_beat = 0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check_reset_outputs();
      rst_n = 1;

      // s0 alone: beats 01..08, four results, last on the fourth
      clk_e = 1; mp_ready = 1; m0_ready = 1; m1_ready = 1; s0_valid = 1;
      mp_hs_count = 0; mp_log.delete();
      for (int i = 0; i < 40 && !draining; i++) begin
         s0_data = 8'(mp_hs_count + 1);
         cycle();
      end
      s0_valid = 0;
      chk("a_beats", mp_hs_count, 8);
      for (int i = 0; i < 8; i++)
         chk("a_mp_seq", mp_log.size() > i ? 32'(mp_log[i]) : 32'hFFFF, i + 1);
      m0_beats = 0; m0_last_beat = 0;
      for (int r = 0; r < 4; r++) begin
         res_valid = 1; res_data = 8'(8'hA0 + r); res_last = (r == 3);
         cycle();
      end
      res_valid = 0; res_last = 0;
      chk("a_m0_beats", m0_beats, 4);
      chk("a_m0_last_beat", m0_last_beat, 4);
      chk("a_busy_after", busy, 0);

      // Simultaneous requests alternate starting with s0
      apply_reset();
      run_job(1, 1, 2, g); chk("tie_grant_1", g, 2'b01);
      run_job(1, 1, 1, g); chk("tie_grant_2", g, 2'b10);
      run_job(1, 1, 3, g); chk("tie_grant_3", g, 2'b01);

      // Clock enable 1 in 3, then a 5-cycle stall on m0_ready while draining
      s0_valid = 1; mp_ready = 1; mp_hs_count = 0;
      for (int i = 0; i < 200 && !draining; i++) begin
         clk_e = (i % 3 == 0);
         s0_data = 8'($urandom);
         cycle();
      end
      s0_valid = 0; clk_e = 1;
      chk("ce_beats", mp_hs_count, 8);
      chk("ce_in_drain", draining, 1);
      m0_ready = 0; res_valid = 1; res_data = 8'h55; res_last = 0;
      for (int i = 0; i < 5; i++) cycle();
      m0_ready = 1; m0_beats = 0;
      for (int r = 0; r < 2; r++) begin
         res_data = 8'(8'h55 + r); res_last = (r == 1);
         cycle();
      end
      res_valid = 0; res_last = 0;
      chk("stall_m0_beats", m0_beats, 2);
      chk("stall_done", busy, 0);

      // Reset in the middle of an s1 job, then a clean s1 job
      s1_valid = 1; mp_ready = 1; mp_hs_count = 0;
      for (int i = 0; i < 20 && mp_hs_count < 3; i++) begin
         s1_data = 8'($urandom);
         cycle();
      end
      chk("mid_beats", mp_hs_count, 3);
      apply_reset();
      run_job(0, 1, 3, g); chk("post_rst_grant", g, 2'b10);

      // JOB_LEN=1 instance: one beat per job, alternating grants
      apply_reset();
      s0_valid = 1; s1_valid = 1; mp_ready = 1; clk_e = 1; res_valid = 0; res_last = 0;
      m0_ready = 1; m1_ready = 1; b_hs_count = 0;
      cycle();
      chk("l1_grant_a", b_grant, 2'b01);  chk("l1_mpv_a", b_mp_valid, 1);
      cycle();
      chk("l1_drain_a", b_mp_valid, 0);   chk("l1_busy_a", b_busy, 1);
      chk("l1_hs_a", b_hs_count, 1);
      res_valid = 1; res_last = 1; res_data = 8'h11;
      cycle();
      chk("l1_idle_a", b_busy, 0);
      res_valid = 0; res_last = 0;
      cycle();
      chk("l1_grant_b", b_grant, 2'b10);
      cycle();
      chk("l1_drain_b", b_mp_valid, 0);   chk("l1_hs_b", b_hs_count, 2);
      res_valid = 1; res_last = 1;
      cycle();
      res_valid = 0; res_last = 0;
      cycle();
      chk("l1_grant_c", b_grant, 2'b01);

      // Randomized traffic against the model
      apply_reset();
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 599) == 0) begin
            apply_reset();
         end else begin
            clk_e     = ($urandom_range(0, 3) != 0);
            s0_valid  = ($urandom_range(0, 9) < 6);
            s1_valid  = ($urandom_range(0, 9) < 6);
            s0_data   = 8'($urandom);
            s1_data   = 8'($urandom);
            mp_ready  = ($urandom_range(0, 9) < 7);
            res_valid = ($urandom_range(0, 1) == 1);
            res_data  = 8'($urandom);
            res_last  = draining ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
            m0_ready  = ($urandom_range(0, 9) < 7);
            m1_ready  = ($urandom_range(0, 9) < 7);
            cycle();
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mat_job_sched.md
MAT_JOB_SCHED -- requirements
Module: mat_job_sched

Interface
REQ-001 Parameter DATA_W, default 8, sets the element and result byte width.
REQ-002 Parameter JOB_LEN, default 8, sets the number of input beats per job (A/B interleaved elements); legal range is 1..255.
REQ-003 i_clk  in  1  single clock for all state.
REQ-004 i_rst_n  in  1  reset; asynchronous assert, active-low.
REQ-005 i_clk_e  in  1  clock enable; state and counters advance only on cycles where it is 1.
REQ-006 s0_data / s0_valid / s0_ready  in / in / out  DATA_W / 1 / 1  requester 0 job input stream.
REQ-007 s1_data / s1_valid / s1_ready  in / in / out  DATA_W / 1 / 1  requester 1 job input stream.
REQ-008 o_mp_data / o_mp_valid / i_mp_ready  out / out / in  DATA_W / 1 / 1  element stream to the multiply datapath.
REQ-009 i_res_data / i_res_valid / i_res_last / o_res_ready  in / in / in / out  DATA_W / 1 / 1 / 1  result stream from the datapath.
REQ-010 m0_data / m0_valid / m0_last / m0_ready  out / out / out / in  DATA_W / 1 / 1 / 1  result stream to requester 0.
REQ-011 m1_data / m1_valid / m1_last / m1_ready  out / out / out / in  DATA_W / 1 / 1 / 1  result stream to requester 1.
REQ-012 o_grant / o_busy  out / out  2 (one-hot) / 1  owner of the datapath; high when not IDLE.

Function
REQ-013 A handshake on any stream is valid&ready&i_clk_e; counters and state change only on handshakes or enabled cycles.
REQ-014 The FSM has three states: IDLE, FEED and DRAIN.
REQ-015 IDLE: if exactly one sN_valid is 1 on an enabled cycle, grant that requester and go to FEED.
REQ-016 IDLE: if both sN_valid are 1, grant the requester that does not hold the last-served flag, then go to FEED.
REQ-017 IDLE: all sN_ready, o_mp_valid and o_res_ready are 0.
REQ-018 FEED: o_mp_data/o_mp_valid mirror the granted sN_data/sN_valid combinationally; the granted sN_ready equals i_mp_ready; the non-granted sN_ready is 0.
REQ-019 FEED: beat counter (8 bits) increments per o_mp handshake; on the handshake that brings it to JOB_LEN, go to DRAIN and clear the counter.
REQ-020 DRAIN: o_mp_valid and all sN_ready are 0.
REQ-021 DRAIN: granted mN_data/valid/last mirror i_res_data/valid/last; o_res_ready equals granted mN_ready; non-granted mN_valid is 0.
REQ-022 DRAIN: a result handshake with i_res_last=1 returns the FSM to IDLE, clears o_grant and sets last-served to the granted requester.
REQ-023 Result beats arriving in FEED (pipelined datapath) are routed to the granted requester exactly as in DRAIN; i_res_last in FEED is forwarded but does not end the job.
REQ-024 i_clk_e=0 freezes FSM, counter, grant and last-served; combinational pass-through still follows inputs, but no handshake is counted.
REQ-025 A requester dropping valid mid-job is not pre-empted; the grant holds until the job completes.
REQ-026 Data passes unmodified; no width conversion and no added latency (zero-cycle pass-through).

Reset
REQ-027 While i_rst_n=0: FSM in IDLE, beat counter 0, o_grant 2'b00, o_busy 0, last-served = requester 1 (so requester 0 wins the first tie), every valid/ready output 0.
REQ-028 Reset asserted mid-job aborts the job immediately with no completion beat; after release, arbitration restarts from REQ-027 state.
REQ-029 Data outputs are don't-care while their valid is 0.

Verification
REQ-030 s0 alone sends 8 beats 0x01..0x08, datapath returns 4 results with last on the 4th -> o_mp sees 01..08 in order, m0 gets 4 beats with m0_last on beat 4, m1_valid stays 0, o_busy falls the cycle after the last handshake.
REQ-031 s0 and s1 both valid out of reset -> s0 is served first, then s1; on the next simultaneous request s0 is served again (strict alternation).
REQ-032 i_clk_e asserted 1 cycle in 3 with s0 valid and i_mp_ready constant 1 -> exactly 8 o_mp handshakes, each on an enabled cycle, then DRAIN.
REQ-033 m0_ready held 0 for 5 cycles in DRAIN -> o_res_ready stays 0 and i_res_data is held; no beat is lost or duplicated.
REQ-034 i_rst_n pulsed low after beat 3 of an s1 job -> all outputs go to 0 asynchronously; afterwards a new s1 job of 8 beats completes normally.
REQ-035 JOB_LEN=1 with back-to-back requests from both requesters -> each job transfers exactly 1 input beat before DRAIN, with alternating grants.
